win_frame_ctrl: RTL
===================

Name: win_frame_ctrl

Overview:
- Frame sequencer for the padded sliding-window block.
- Accepts a per-frame geometry command and drives the window block's frame_h/frame_w/frame_start.
- Issues row-by-row read requests to the multi-row line buffer, gated by line-buffer fill level and downstream readiness.
- Generates the delayed din_vld for the window block, counts returned win_vld beats, and reports frame completion.

Parameters:
FRAME_H_MAX, 224, maximum frame height
FRAME_W_MAX, 224, maximum frame width
WIN_SIZE, 3, window size (odd, >=3); WIN_R = WIN_SIZE/2
RD_LAT, 2, line-buffer read latency in cycles (>=1)
ROW_GAP, 2, idle cycles inserted after each row (>=0)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_vld  in  1  geometry command valid
cfg_rdy  out  1  ready to accept command
cfg_h  in  clog2(FRAME_H_MAX-1)+1  frame height
cfg_w  in  clog2(FRAME_W_MAX-1)+1  frame width
rows_avail  in  clog2(FRAME_H_MAX)+1  complete rows currently held by line buffer
ds_rdy  in  1  downstream can absorb one more output row
rd_en  out  1  line-buffer read strobe
rd_row  out  clog2(FRAME_H_MAX-1)+1  centre row index of read
rd_col  out  clog2(FRAME_W_MAX-1)+1  column index of read
frame_h  out  clog2(FRAME_H_MAX-1)+1  latched height to window block
frame_w  out  clog2(FRAME_W_MAX-1)+1  latched width to window block
frame_start  out  1  one-cycle frame start pulse to window block
din_vld  out  1  rd_en delayed by RD_LAT
win_vld  in  1  window valid from window block
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last window
cfg_err  out  1  one-cycle pulse on rejected command

Behaviour:
- Clock: single clock clk. Reset: reset_n is asynchronous and active-low. Reset value of all outputs and state is 0, except cfg_rdy (=1 in IDLE after reset) and state=IDLE.
- FSM states:
  - IDLE: cfg_rdy=1. On cfg_vld, latch cfg_h/cfg_w.
    - If legal (WIN_SIZE<=h<=FRAME_H_MAX and WIN_SIZE<=w<=FRAME_W_MAX): go to START.
    - Else pulse cfg_err for 1 cycle, drop the command, stay in IDLE.
  - START: frame_start=1 for exactly 1 cycle. frame_h/frame_w already valid (driven from the latch, held until the next accepted command). Clear r, c and the output counters. Go to WAIT_ROW.
  - WAIT_ROW: leave for ROW when ds_rdy=1 and rows_avail >= min(r+WIN_R+1, h).
  - ROW: rd_en=1 every cycle, rd_row=r, rd_col=c, c increments 0..w-1. No stall inside a row; ds_rdy/rows_avail are ignored mid-row. At c=w-1: c<=0, r<=r+1, go to GAP.
  - GAP: ROW_GAP idle cycles (ROW_GAP=0 skips the state). Then go to WAIT_ROW if r<h, else DRAIN.
  - DRAIN: wait until the output counter reaches h*w, then go to DONE.
  - DONE: frame_done=1 for 1 cycle, go to IDLE.
- busy=1 in every state except IDLE. cfg_rdy=1 only in IDLE.
- din_vld: rd_en passed through an RD_LAT-stage shift register, so din_vld(t) = rd_en(t-RD_LAT).
- Output counting:
  - A column counter oc and row counter or advance on win_vld (oc wraps at w-1, or increments on wrap).
  - Reaching or==h is "all windows received"; no h*w multiplier.
  - win_vld while in IDLE/START is ignored and does not count.
- Widths: r spans 0..h, so it uses clog2(FRAME_H_MAX)+1 bits; comparisons are unsigned. The min() term is computed at the same width.
- Boundary rows:
  - The last WIN_R rows need only h rows available, not r+WIN_R+1; the window block pads them.
  - The first row needs WIN_R+1 rows.
- Simultaneous events:
  - cfg_vld during busy is not accepted (cfg_rdy=0); the command stays pending.
  - win_vld arriving in the same cycle as the DRAIN check counts before the compare (next-value compare).
- Reset mid-frame aborts immediately: rd_en, din_vld pipe, frame_start and counters all clear; no frame_done is issued.

Decomposition:
- Package win_pkg:
  - win_state_t enum (IDLE, START, WAIT_ROW, ROW, GAP, DRAIN, DONE).
  - Width constants derived via clog2 for H/W.
  - WIN_R function.
- One sub-module: vld_delay_line (parameter DEPTH=RD_LAT), a reset-to-0 shift register producing din_vld.

Test Plan:
- Legal frame, all rows available: h=4, w=5, WIN_SIZE=3, RD_LAT=2, ROW_GAP=2, rows_avail=4, ds_rdy=1 -> frame_start 1 cycle after acceptance; 4 bursts of 5 rd_en with rd_col 0..4 and 2-cycle gaps; din_vld = rd_en delayed 2; frame_done 1 cycle after 20th win_vld.
- Line-buffer starvation: rows_avail held at 1 -> no rd_en. Raise rows_avail to 2 -> row 0 issued. Rows 2 and 3 both wait only for rows_avail=4.
- Backpressure: ds_rdy=0 at the row 1 boundary for 10 cycles -> WAIT_ROW holds; rd_en stays 0; the row resumes the cycle after ds_rdy=1. Dropping ds_rdy mid-row does not interrupt the burst.
- Illegal command: cfg_h=2 (<WIN_SIZE) or cfg_w=FRAME_W_MAX+1 -> cfg_err pulse, busy stays 0, frame_start never asserted.
- Command while busy: second cfg_vld held during frame -> cfg_rdy=0 until after frame_done; the second frame starts with new frame_h/frame_w.
- Reset mid-row: reset_n low at rd_col=2 of row 1 -> all outputs 0 asynchronously; after release, state IDLE, cfg_rdy=1, no frame_done.

Source files
------------

// File: rtl/win_pkg.sv
// Shared state encoding and width helpers for the frame sequencer and its bus interface.
package win_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_ROW = 3'd2,
        ROW      = 3'd3,
        GAP      = 3'd4,
        DRAIN    = 3'd5,
        DONE     = 3'd6
    } win_state_t;

    localparam int FRAME_H_MAX_DEF = 224;
    localparam int FRAME_W_MAX_DEF = 224;

    // Width of a geometry field (frame_h, rd_col, ...).
    function automatic int dim_bits(input int max_val);
        return $clog2(max_val - 1) + 1;
    endfunction

    // Width of a row counter that must also hold max_val itself.
    function automatic int cnt_bits(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    function automatic int win_r(input int win_size);
        return win_size / 2;
    endfunction

endpackage

// File: rtl/win_frame_if.sv
// Bus between the frame sequencer (master) and its line buffer / window block environment (slave).
interface win_frame_if #(
    parameter int FRAME_H_MAX = 224,
    parameter int FRAME_W_MAX = 224
);
    import win_pkg::*;

    localparam int HW = dim_bits(FRAME_H_MAX);
    localparam int WW = dim_bits(FRAME_W_MAX);
    localparam int RW = cnt_bits(FRAME_H_MAX);

    logic          cfg_vld;
    logic          cfg_rdy;
    logic [HW-1:0] cfg_h;
    logic [WW-1:0] cfg_w;
    logic          cfg_err;
    logic [RW-1:0] rows_avail;
    logic          ds_rdy;
    logic          rd_en;
    logic [HW-1:0] rd_row;
    logic [WW-1:0] rd_col;
    logic [HW-1:0] frame_h;
    logic [WW-1:0] frame_w;
    logic          frame_start;
    logic          din_vld;
    logic          win_vld;
    logic          busy;
    logic          frame_done;

    modport master (
        input  cfg_vld, cfg_h, cfg_w, rows_avail, ds_rdy, win_vld,
        output cfg_rdy, cfg_err, rd_en, rd_row, rd_col, frame_h, frame_w,
               frame_start, din_vld, busy, frame_done
    );

    modport slave (
        output cfg_vld, cfg_h, cfg_w, rows_avail, ds_rdy, win_vld,
        input  cfg_rdy, cfg_err, rd_en, rd_row, rd_col, frame_h, frame_w,
               frame_start, din_vld, busy, frame_done
    );

endinterface

// File: rtl/vld_delay_line.sv
// Reset-to-zero shift register: dout repeats din DEPTH clocks later.
module vld_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] sr_r;

    // Shift din through DEPTH flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r <= '0;
        end else begin
            sr_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_r[i] <= sr_r[i-1];
            end
        end
    end

    assign dout = sr_r[DEPTH-1];

endmodule

// File: rtl/win_frame_ctrl.sv
// Frame sequencer: accepts a geometry command, paces row reads out of the line buffer
// and counts returned windows to signal frame completion.
module win_frame_ctrl
    import win_pkg::*;
#(
    parameter int FRAME_H_MAX = FRAME_H_MAX_DEF,
    parameter int FRAME_W_MAX = FRAME_W_MAX_DEF,
    parameter int WIN_SIZE    = 3,
    parameter int RD_LAT      = 2,
    parameter int ROW_GAP     = 2
) (
    input logic         clk,
    input logic         reset_n,
    win_frame_if.master bus
);
    localparam int HW    = dim_bits(FRAME_H_MAX);
    localparam int WW    = dim_bits(FRAME_W_MAX);
    localparam int RW    = cnt_bits(FRAME_H_MAX);
    localparam int GW    = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
    localparam int WIN_R = win_r(WIN_SIZE);

    localparam logic [2:0] S_IDLE     = IDLE;
    localparam logic [2:0] S_START    = START;
    localparam logic [2:0] S_WAIT_ROW = WAIT_ROW;
    localparam logic [2:0] S_ROW      = ROW;
    localparam logic [2:0] S_GAP      = GAP;
    localparam logic [2:0] S_DRAIN    = DRAIN;
    localparam logic [2:0] S_DONE     = DONE;

    logic [2:0]    state_r, state_s;
    logic [RW-1:0] r_r, r_s, orow_r, orow_s;
    logic [RW-1:0] h_ext_s, row_top_s, need_s;
    logic [WW-1:0] c_r, c_s, ocol_r, ocol_s, w_last_s;
    logic [GW-1:0] gap_r, gap_s;
    logic [HW-1:0] frame_h_r;
    logic [WW-1:0] frame_w_r;
    logic          legal_s, latch_s, err_s, count_en_s;
    logic          cfg_rdy_r, cfg_err_r, busy_r, frame_start_r, frame_done_r, rd_en_r;
    logic          din_vld_s;

    assign legal_s = (bus.cfg_h >= HW'(WIN_SIZE)) && (bus.cfg_h <= HW'(FRAME_H_MAX)) &&
                     (bus.cfg_w >= WW'(WIN_SIZE)) && (bus.cfg_w <= WW'(FRAME_W_MAX));

    assign h_ext_s    = RW'(frame_h_r);
    assign w_last_s   = frame_w_r - WW'(1);
    // Bottom rows are padded by the window block, so never demand more than h rows.
    assign row_top_s  = r_r + RW'(WIN_R + 1);
    assign need_s     = (row_top_s > h_ext_s) ? h_ext_s : row_top_s;
    assign count_en_s = (state_r != S_IDLE) && (state_r != S_START);

    // Next-state, read-position and gap-counter decode
    always_comb begin
        state_s = state_r;
        r_s     = r_r;
        c_s     = c_r;
        gap_s   = gap_r;
        latch_s = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.cfg_vld && legal_s) begin
                    latch_s = 1'b1;
                    state_s = S_START;
                end else if (bus.cfg_vld) begin
                    err_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                r_s     = '0;
                c_s     = '0;
                state_s = S_WAIT_ROW;
            end
            S_WAIT_ROW: begin
                if (bus.ds_rdy && (bus.rows_avail >= need_s)) begin
                    state_s = S_ROW;
                end else begin
                    state_s = S_WAIT_ROW;
                end
            end
            S_ROW: begin
                if (c_r == w_last_s) begin
                    c_s   = '0;
                    r_s   = r_r + RW'(1);
                    gap_s = '0;
                    if (ROW_GAP == 0) begin
                        state_s = (r_s < h_ext_s) ? S_WAIT_ROW : S_DRAIN;
                    end else begin
                        state_s = S_GAP;
                    end
                end else begin
                    c_s = c_r + WW'(1);
                end
            end
            S_GAP: begin
                if (gap_r == GW'(ROW_GAP - 1)) begin
                    state_s = (r_r < h_ext_s) ? S_WAIT_ROW : S_DRAIN;
                end else begin
                    gap_s = gap_r + GW'(1);
                end
            end
            S_DRAIN: begin
                if (orow_s == h_ext_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Returned-window counters; the DRAIN exit compares the post-increment value
    always_comb begin
        ocol_s = ocol_r;
        orow_s = orow_r;
        if (count_en_s && bus.win_vld && (orow_r != h_ext_s)) begin
            if (ocol_r == w_last_s) begin
                ocol_s = '0;
                orow_s = orow_r + RW'(1);
            end else begin
                ocol_s = ocol_r + WW'(1);
            end
        end else begin
            ocol_s = ocol_r;
            orow_s = orow_r;
        end
    end

    // State, counters and geometry latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_IDLE;
            r_r       <= '0;
            c_r       <= '0;
            gap_r     <= '0;
            ocol_r    <= '0;
            orow_r    <= '0;
            frame_h_r <= '0;
            frame_w_r <= '0;
        end else begin
            state_r <= state_s;
            r_r     <= r_s;
            c_r     <= c_s;
            gap_r   <= gap_s;
            if (state_r == S_START) begin
                ocol_r <= '0;
                orow_r <= '0;
            end else begin
                ocol_r <= ocol_s;
                orow_r <= orow_s;
            end
            if (latch_s) begin
                frame_h_r <= bus.cfg_h;
                frame_w_r <= bus.cfg_w;
            end else begin
                frame_h_r <= frame_h_r;
                frame_w_r <= frame_w_r;
            end
        end
    end

    // Status/strobe outputs registered from the next state so they align with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_rdy_r     <= 1'b1;
            cfg_err_r     <= 1'b0;
            busy_r        <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            rd_en_r       <= 1'b0;
        end else begin
            cfg_rdy_r     <= (state_s == S_IDLE);
            cfg_err_r     <= err_s;
            busy_r        <= (state_s != S_IDLE);
            frame_start_r <= (state_s == S_START);
            frame_done_r  <= (state_s == S_DONE);
            rd_en_r       <= (state_s == S_ROW);
        end
    end

    vld_delay_line #(
        .DEPTH (RD_LAT)
    ) u_vld_dly (
        .clk   (clk),
        .rst_n (reset_n),
        .din   (rd_en_r),
        .dout  (din_vld_s)
    );

    assign bus.cfg_rdy     = cfg_rdy_r;
    assign bus.cfg_err     = cfg_err_r;
    assign bus.busy        = busy_r;
    assign bus.frame_start = frame_start_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.rd_en       = rd_en_r;
    assign bus.rd_row      = HW'(r_r);
    assign bus.rd_col      = c_r;
    assign bus.frame_h     = frame_h_r;
    assign bus.frame_w     = frame_w_r;
    assign bus.din_vld     = din_vld_s;

endmodule
